// File: rtl/demux_pkg.sv
// demux_pkg: shared types and constants for the 1-to-2 buffered stream demux.
//   lock_state_e    : packet-lock FSM encoding (used when DEMUX_1TO2_PKT_LOCK_EN is defined)
//   DEMUX_BUF_DEPTH : entries per output buffer
//   DEMUX_CNT_W     : width of a buffer occupancy count
package demux_pkg;

    localparam int unsigned DEMUX_BUF_DEPTH = 2;
    localparam int unsigned DEMUX_CNT_W     = $clog2(DEMUX_BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOCK_ZERO = 2'd1,
        LOCK_ONE  = 2'd2
    } lock_state_e;

endpackage

// File: rtl/demux_skid2.sv
// demux_skid2: 2-entry order-preserving FIFO, shift organised so the head is
// always entry 0 and comes straight from a flop.
//   clk, rst_n   : clock, async active-low reset
//   push, din    : write request and payload (ignored when full)
//   pop          : read request (ignored when empty)
//   count        : registered occupancy
//   count_nxt_c  : occupancy after this cycle's push/pop (combinational)
//   valid        : registered count != 0
//   head         : registered head entry
module demux_skid2
    import demux_pkg::*;
#(
    parameter int unsigned W = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [DEMUX_CNT_W-1:0] count,
    output logic [DEMUX_CNT_W-1:0] count_nxt_c,
    output logic                   valid,
    output logic [W-1:0]           head
);

    localparam logic [DEMUX_CNT_W-1:0] FULL = DEMUX_CNT_W'(DEMUX_BUF_DEPTH);

    logic [W-1:0]           e0_q, e0_d;
    logic [W-1:0]           e1_q, e1_d;
    logic [DEMUX_CNT_W-1:0] cnt_q, cnt_d;
    logic                   valid_q, valid_d;
    logic                   do_pop, do_push;

    // Pop shifts entry 1 forward first; a push then lands in the first free slot.
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        cnt_d   = cnt_q;
        do_pop  = pop && (cnt_q != '0);
        do_push = push && (cnt_q != FULL);
        if (do_pop) begin
            e0_d  = e1_q;
            cnt_d = cnt_q - DEMUX_CNT_W'(1);
        end
        if (do_push) begin
            if (cnt_d == '0) begin
                e0_d = din;
            end else begin
                e1_d = din;
            end
            cnt_d = cnt_d + DEMUX_CNT_W'(1);
        end
        valid_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q    <= '0;
            e1_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign count       = cnt_q;
    assign count_nxt_c = cnt_d;
    assign valid       = valid_q;
    assign head        = e0_q;

endmodule

// File: rtl/demux_1to2_buf.sv
// demux_1to2_buf: registered 1-to-2 valid/ready stream demux with a 2-entry
// buffer per output so the outputs drain independently.
//   clk, rst_n                       : clock, async active-low reset
//   in_valid/in_ready/in_data/in_sel/in_last : producer stream, in_sel picks output
//   zero_valid/zero_ready/zero_data/zero_last : output 0 stream
//   one_valid/one_ready/one_data/one_last     : output 1 stream
// Build option: DEMUX_1TO2_PKT_LOCK_EN adds a packet-lock FSM that keeps every
// beat of a packet on the output chosen by its first beat.
module demux_1to2_buf
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_last,
    output logic             zero_valid,
    input  logic             zero_ready,
    output logic [WIDTH-1:0] zero_data,
    output logic             zero_last,
    output logic             one_valid,
    input  logic             one_ready,
    output logic [WIDTH-1:0] one_data,
    output logic             one_last
);

    localparam int unsigned            ENT_W = WIDTH + 1;
    localparam logic [DEMUX_CNT_W-1:0] FULL  = DEMUX_CNT_W'(DEMUX_BUF_DEPTH);

    logic                   in_ready_q, in_ready_d;
    logic                   accept;
    logic                   route_one;
    logic [DEMUX_CNT_W-1:0] zero_cnt, zero_cnt_nxt;
    logic [DEMUX_CNT_W-1:0] one_cnt, one_cnt_nxt;
    logic [ENT_W-1:0]       zero_head, one_head;

    assign accept = in_valid && in_ready_q;

`ifdef DEMUX_1TO2_PKT_LOCK_EN
    lock_state_e state_q, state_d;

    // Routing and next state: a locked packet ignores in_sel until its last beat.
    always_comb begin
        state_d   = state_q;
        route_one = in_sel;
        case (state_q)
            LOCK_ZERO: route_one = 1'b0;
            LOCK_ONE:  route_one = 1'b1;
            default:   route_one = in_sel;
        endcase
        if (accept) begin
            if (in_last) begin
                state_d = IDLE;
            end else if (state_q == IDLE) begin
                state_d = in_sel ? LOCK_ONE : LOCK_ZERO;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`else
    assign route_one = in_sel;
`endif

    demux_skid2 #(.W(ENT_W)) u_buf_zero (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (accept && !route_one),
        .din         ({in_data, in_last}),
        .pop         (zero_valid && zero_ready),
        .count       (zero_cnt),
        .count_nxt_c (zero_cnt_nxt),
        .valid       (zero_valid),
        .head        (zero_head)
    );

    demux_skid2 #(.W(ENT_W)) u_buf_one (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (accept && route_one),
        .din         ({in_data, in_last}),
        .pop         (one_valid && one_ready),
        .count       (one_cnt),
        .count_nxt_c (one_cnt_nxt),
        .valid       (one_valid),
        .head        (one_head)
    );

    // in_ready is registered from next occupancy, so it equals a decode of the
    // current counts without any combinational path from the input side.
    always_comb begin
        in_ready_d = (zero_cnt_nxt != FULL) && (one_cnt_nxt != FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign zero_data = zero_head[ENT_W-1:1];
    assign zero_last = zero_head[0];
    assign one_data  = one_head[ENT_W-1:1];
    assign one_last  = one_head[0];

endmodule

// File: tb/tb_demux_1to2_buf.sv
// tb_demux_1to2_buf: directed self-checking bench for demux_1to2_buf (WIDTH=8).
// Lock-mode expectations follow DEMUX_1TO2_PKT_LOCK_EN when it is defined.
module tb_demux_1to2_buf;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_sel;
    logic       in_last;
    logic       zero_valid;
    logic       zero_ready;
    logic [7:0] zero_data;
    logic       zero_last;
    logic       one_valid;
    logic       one_ready;
    logic [7:0] one_data;
    logic       one_last;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    demux_1to2_buf #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_last    (in_last),
        .zero_valid (zero_valid),
        .zero_ready (zero_ready),
        .zero_data  (zero_data),
        .zero_last  (zero_last),
        .one_valid  (one_valid),
        .one_ready  (one_ready),
        .one_data   (one_data),
        .one_last   (one_last)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; all driving and sampling happens 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic s, input logic l);
        in_valid = v;
        in_data  = d;
        in_sel   = s;
        in_last  = l;
    endtask

    initial begin
        rst_n      = 1'b0;
        zero_ready = 1'b1;
        one_ready  = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Reset state
        step();
        step();
        check("rst_zero_valid", 32'(zero_valid), 32'h0);
        check("rst_one_valid",  32'(one_valid),  32'h0);
        check("rst_zero_data",  32'(zero_data),  32'h0);
        check("rst_one_data",   32'(one_data),   32'h0);
        rst_n = 1'b1;
        step();
        check("rel_in_ready",   32'(in_ready),   32'h1);
        check("rel_zero_valid", 32'(zero_valid), 32'h0);
        check("rel_one_valid",  32'(one_valid),  32'h0);

        // Streaming 0x11/0x22/0x33, both consumers ready
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        step();
        check("s1_zero_valid", 32'(zero_valid), 32'h1);
        check("s1_zero_data",  32'(zero_data),  32'h11);
        check("s1_in_ready",   32'(in_ready),   32'h1);
        drive(1'b1, 8'h22, 1'b1, 1'b0);
        step();
        check("s2_one_valid",  32'(one_valid),  32'h1);
        check("s2_one_data",   32'(one_data),   32'h22);
        check("s2_zero_valid", 32'(zero_valid), 32'h0);
        check("s2_in_ready",   32'(in_ready),   32'h1);
        drive(1'b1, 8'h33, 1'b0, 1'b1);
        step();
        check("s3_zero_data",  32'(zero_data),  32'h33);
        check("s3_zero_last",  32'(zero_last),  32'h1);
        check("s3_one_valid",  32'(one_valid),  32'h0);
        check("s3_in_ready",   32'(in_ready),   32'h1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        check("s4_zero_valid", 32'(zero_valid), 32'h0);

        // Head-of-line stall with zero_ready low
        zero_ready = 1'b0;
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        step();
        check("h1_in_ready",  32'(in_ready),  32'h1);
        drive(1'b1, 8'h02, 1'b0, 1'b0);
        step();
        check("h2_in_ready",  32'(in_ready),  32'h0);
        check("h2_zero_data", 32'(zero_data), 32'h01);
        drive(1'b1, 8'h03, 1'b1, 1'b0);
        step();
        check("h3_in_ready",  32'(in_ready),  32'h0);
        check("h3_one_valid", 32'(one_valid), 32'h0);
        step();
        check("h4_one_valid", 32'(one_valid), 32'h0);
        zero_ready = 1'b1;
        step();
        check("h5_zero_data", 32'(zero_data), 32'h02);
        check("h5_in_ready",  32'(in_ready),  32'h1);
        check("h5_one_valid", 32'(one_valid), 32'h0);
        step();
        check("h6_one_valid",  32'(one_valid),  32'h1);
        check("h6_one_data",   32'(one_data),   32'h03);
        check("h6_zero_valid", 32'(zero_valid), 32'h0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        check("h7_one_valid", 32'(one_valid), 32'h0);

        // Simultaneous push and pop on zero with both buffers at count 1
        zero_ready = 1'b0;
        one_ready  = 1'b0;
        drive(1'b1, 8'hA0, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'hB0, 1'b1, 1'b0);
        step();
        check("pp_head_before", 32'(zero_data), 32'hA0);
        check("pp_one_data",    32'(one_data),  32'hB0);
        zero_ready = 1'b1;
        drive(1'b1, 8'hA1, 1'b0, 1'b0);
        step();
        check("pp_zero_valid",  32'(zero_valid), 32'h1);
        check("pp_head_after",  32'(zero_data),  32'hA1);
        check("pp_in_ready",    32'(in_ready),   32'h1);
        zero_ready = 1'b0;
        drive(1'b1, 8'hA2, 1'b0, 1'b0);
        step();
        check("pp_fill_ready",  32'(in_ready),   32'h0);
        check("pp_fill_head",   32'(zero_data),  32'hA1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        zero_ready = 1'b1;
        one_ready  = 1'b1;
        step();
        check("pp_drain_a2",    32'(zero_data),  32'hA2);
        step();
        check("pp_drain_zero",  32'(zero_valid), 32'h0);
        check("pp_drain_one",   32'(one_valid),  32'h0);

        // Asynchronous reset mid-stream
        zero_ready = 1'b0;
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        step();
        check("mr_zero_valid", 32'(zero_valid), 32'h1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mr_async_valid", 32'(zero_valid), 32'h0);
        check("mr_async_data",  32'(zero_data),  32'h0);
        step();
        rst_n      = 1'b1;
        zero_ready = 1'b1;
        step();
        check("mr_in_ready",   32'(in_ready),   32'h1);
        check("mr_zero_empty", 32'(zero_valid), 32'h0);

        // Packet routing (locked when the feature is built in)
        drive(1'b1, 8'h10, 1'b1, 1'b0);
        step();
        check("pk1_one_data",   32'(one_data),   32'h10);
        check("pk1_zero_valid", 32'(zero_valid), 32'h0);
        drive(1'b1, 8'h20, 1'b0, 1'b0);
        step();
`ifdef DEMUX_1TO2_PKT_LOCK_EN
        check("pk2_one_data",   32'(one_data),   32'h20);
        check("pk2_zero_valid", 32'(zero_valid), 32'h0);
`else
        check("pk2_zero_data",  32'(zero_data),  32'h20);
        check("pk2_one_valid",  32'(one_valid),  32'h0);
`endif
        drive(1'b1, 8'h30, 1'b0, 1'b1);
        step();
`ifdef DEMUX_1TO2_PKT_LOCK_EN
        check("pk3_one_data",   32'(one_data),   32'h30);
        check("pk3_one_last",   32'(one_last),   32'h1);
        check("pk3_zero_valid", 32'(zero_valid), 32'h0);
`else
        check("pk3_zero_data",  32'(zero_data),  32'h30);
        check("pk3_zero_last",  32'(zero_last),  32'h1);
`endif
        drive(1'b1, 8'h40, 1'b0, 1'b1);
        step();
        check("pk4_zero_data",  32'(zero_data),  32'h40);
        check("pk4_one_valid",  32'(one_valid),  32'h0);

        // Reset while a packet to one is open, then route to zero
        drive(1'b1, 8'h50, 1'b1, 1'b0);
        step();
        check("lr_one_data", 32'(one_data), 32'h50);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        drive(1'b1, 8'h60, 1'b0, 1'b1);
        step();
        check("lr_zero_valid", 32'(zero_valid), 32'h1);
        check("lr_zero_data",  32'(zero_data),  32'h60);
        check("lr_one_valid",  32'(one_valid),  32'h0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/demux_1to2_buf.md
# demux_1to2_buf

Registered 1-to-2 stream demultiplexer, the write-side counterpart of the 2:1 mux family. Each accepted input beat goes to output `zero` or output `one`. Each output has its own 2-entry buffer, so the outputs drain independently. The block sits in front of the carry-select and datapath muxes, where it splits one producer stream between two consumer lanes with valid/ready flow control.

## Interface
- `WIDTH`, default 8: data width in bits; legal range 1..8.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  input beat present.
- `in_ready`  output  1  block accepts the beat this cycle.
- `in_data`  input  WIDTH  input payload.
- `in_sel`  input  1  0 routes the beat to `zero`, 1 routes it to `one`.
- `in_last`  input  1  last beat of a packet.
- `zero_valid`  output  1  output 0 beat present.
- `zero_ready`  input  1  output 0 consumer accepts.
- `zero_data`  output  WIDTH  output 0 payload.
- `zero_last`  output  1  output 0 last flag.
- `one_valid`, `one_ready`, `one_data`, `one_last`: same as the `zero_*` ports, for output 1.

## Operation
- A beat transfers on any port when valid && ready at the rising edge of `clk`.
- Valid must not drop and payload must not change until the transfer. Ready may toggle freely.
- `in_ready` = (zero count < 2) && (one count < 2).
  - Decoded from registers only.
  - No combinational path from `in_sel`, `in_valid` or any `*_ready` to `in_ready`.
- An accepted beat writes {data, last} into the selected output buffer. The other buffer is untouched.
- Each output buffer is a 2-entry FIFO with order preserved.
  - Output valid = count != 0.
  - Output data/last = head entry.
- Push and pop in the same cycle on one buffer: count unchanged, and the new entry queues behind the head.
- Pop on an empty buffer cannot occur, because valid is low.
- Push on a full buffer cannot occur, because `in_ready` is low.
- Beats to the two outputs never reorder within an output. No ordering relation is kept between the two outputs.
- Reset, asynchronous, including mid-packet:
  - Both counts 0 and all buffered beats discarded.
  - `zero_valid` = `one_valid` = 0; `*_data` = 0; `*_last` = 0.
  - `in_ready` = 1 once `rst_n` is high.
  - Lock FSM returns to IDLE.

## Timing
- Latency: a beat accepted at edge N is visible on its output from edge N, i.e. in cycle N+1.
- Throughput: 1 beat/cycle sustained when the destination consumer holds ready high.
- `in_ready` falls in the cycle after either buffer reaches 2 entries.
- `in_ready` rises in the cycle after that buffer pops.
- With `zero_ready` held low: at most 2 beats accepted for `zero` before stall.
  - The stall also blocks beats destined for `one`. This head-of-line block is intended.

## Configuration
- Macro: `DEMUX_1TO2_PKT_LOCK_EN`.
- Defined: a 3-state lock FSM controls routing.
  - States: IDLE, LOCK_ZERO, LOCK_ONE.
  - IDLE: the beat routes per `in_sel`.
  - IDLE, accepted beat with `in_last`=0: go to LOCK_ZERO if `in_sel`=0, LOCK_ONE if `in_sel`=1.
  - IDLE, accepted beat with `in_last`=1: stay in IDLE.
  - LOCK_x: `in_sel` is ignored and beats route to output x.
  - LOCK_x, accepted beat with `in_last`=1: return to IDLE.
  - No transition without an accepted beat.
  - Reset state: IDLE.
- Undefined: no FSM; every beat routes on its own `in_sel`. `in_last` is carried through only.

## Structure
- Shared package `demux_pkg`:
  - Lock-state encoding: IDLE=2'd0, LOCK_ZERO=2'd1, LOCK_ONE=2'd2.
  - `DEMUX_BUF_DEPTH`=2.
- Sub-module `demux_skid2`: 2-entry FIFO, WIDTH+1 bits wide. Ports: push/pop, count, head. Instantiated once per output.
- Top level holds only the routing decode, the `in_ready` decode and the lock FSM.

## Test plan
- Reset with `rst_n`=0 mid-stream:
  - During reset: all `*_valid`=0, all `*_data`=0.
  - First cycle after release: `in_ready`=1 and both buffers empty.
- Stream 0x11, 0x22, 0x33 with `in_sel`=0,1,0, both consumers always ready:
  - `zero_data` shows 0x11 then 0x33.
  - `one_data` shows 0x22.
  - 1 beat/cycle with no `in_ready` dropout.
- `zero_ready`=0, send 0x01, 0x02 to `zero`, then 0x03 to `one`:
  - `in_ready` goes low after the 2nd beat.
  - 0x03 is held off until `zero_ready`=1 pops one entry.
- With both buffers at count 1, push and pop on `zero` in the same cycle:
  - Count stays 1; head order is preserved (0xA0 then 0xA1).
- `DEMUX_1TO2_PKT_LOCK_EN` defined; packet 0x10 (`in_sel`=1, last=0), 0x20 (`in_sel`=0, last=0), 0x30 (`in_sel`=0, last=1):
  - All three beats appear on `one`.
  - The next beat with `in_sel`=0 goes to `zero`.
- Assert `rst_n` low while in LOCK_ONE:
  - FSM returns to IDLE.
  - The next beat with `in_sel`=0 lands on `zero`.
